// File: rtl/atm_pin_entry_if.sv
// Keypad / card-reader signal bundle for the ATM PIN entry controller.
interface atm_pin_entry_if;
   localparam int unsigned PIN_W = 14;
   localparam int unsigned KEY_W = 4;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned TRY_W = 2;

   logic             card_present;
   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic [PIN_W-1:0] stored_pin;
   logic [PIN_W-1:0] pin_value;
   logic [CNT_W-1:0] digit_count;
   logic             pin_ok;
   logic             pin_fail;
   logic [TRY_W-1:0] tries;
   logic             card_retain;
   logic             card_eject;
   logic             timeout;

   modport master (output card_present, key_valid, key_code, stored_pin,
                   input  pin_value, digit_count, pin_ok, pin_fail, tries,
                          card_retain, card_eject, timeout);

   modport slave  (input  card_present, key_valid, key_code, stored_pin,
                   output pin_value, digit_count, pin_ok, pin_fail, tries,
                          card_retain, card_eject, timeout);
endinterface

// File: rtl/atm_pin_entry.sv
// ATM PIN entry controller: collects four digits, checks them against the card PIN,
// and retains the card after MAX_TRIES failures. Define PIN_TIMEOUT_EN for the keypress timer.
module atm_pin_entry #(
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 30000000
) (
   input logic            clk,
   input logic            reset,
   atm_pin_entry_if.slave bus
);
   localparam int unsigned PIN_W      = 14;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned TRY_W      = 2;
   localparam int unsigned NUM_DIGITS = 4;

   typedef enum logic [2:0] {IDLE, COLLECT, CHECK, GRANTED, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [PIN_W-1:0] pin_value_q, pin_value_d;
   logic [CNT_W-1:0] digit_count_q, digit_count_d;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic             pin_ok_q, pin_ok_d;
   logic             pin_fail_q, pin_fail_d;
   logic             card_retain_q, card_retain_d;
   logic             card_eject_q, card_eject_d;
   logic             card_prev_q;
   logic             card_edge;
   logic             is_digit;
   logic [TRY_W:0]   tries_inc;

   assign card_edge = bus.card_present && !card_prev_q;
   assign is_digit  = (bus.key_code <= 4'd9);
   assign tries_inc = (TRY_W+1)'(tries_q) + (TRY_W+1)'(1);

`ifdef PIN_TIMEOUT_EN
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timer_expired;
   logic             timeout_q, timeout_d;

   assign timer_expired = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   // Idle-keypress timer: runs only while collecting, any key restarts it
   always_comb begin
      timer_d = '0;
      if (state_q == COLLECT && bus.card_present && !bus.key_valid && !timer_expired)
         timer_d = timer_q + TMR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      pin_value_d   = pin_value_q;
      digit_count_d = digit_count_q;
      tries_d       = tries_q;
      pin_fail_d    = 1'b0;
      card_eject_d  = 1'b0;
`ifdef PIN_TIMEOUT_EN
      timeout_d     = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (card_edge) begin
               state_d       = COLLECT;
               pin_value_d   = '0;
               digit_count_d = '0;
               tries_d       = '0;
            end
         end
         COLLECT: begin
            if (!bus.card_present) begin
               state_d = IDLE;
            end else if (bus.key_valid) begin
               if (is_digit) begin
                  if (digit_count_q < CNT_W'(NUM_DIGITS)) begin
                     pin_value_d   = PIN_W'(pin_value_q * PIN_W'(10)) + PIN_W'(bus.key_code);
                     digit_count_d = digit_count_q + CNT_W'(1);
                  end
               end else begin
                  case (bus.key_code)
                     4'hA: begin
                        pin_value_d   = '0;
                        digit_count_d = '0;
                     end
                     4'hB: if (digit_count_q == CNT_W'(NUM_DIGITS)) state_d = CHECK;
                     4'hC: begin
                        card_eject_d = 1'b1;
                        state_d      = IDLE;
                     end
                     default: ;
                  endcase
               end
            end
`ifdef PIN_TIMEOUT_EN
            else if (timer_expired) begin
               timeout_d    = 1'b1;
               card_eject_d = 1'b1;
               state_d      = IDLE;
            end
`endif
         end
         CHECK: begin
            if (!bus.card_present) begin
               state_d = IDLE;
            end else if (pin_value_q == bus.stored_pin) begin
               state_d = GRANTED;
            end else begin
               pin_fail_d    = 1'b1;
               tries_d       = TRY_W'(tries_inc);
               pin_value_d   = '0;
               digit_count_d = '0;
               state_d       = (32'(tries_inc) >= MAX_TRIES) ? LOCKED : COLLECT;
            end
         end
         GRANTED: if (!bus.card_present) state_d = IDLE;
         LOCKED:  ;
         default: state_d = IDLE;
      endcase
      pin_ok_d      = (state_d == GRANTED);
      card_retain_d = (state_d == LOCKED);
   end

   // Card edge detector powers up "present" so a card left in across reset needs re-insertion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pin_value_q   <= '0;
         digit_count_q <= '0;
         tries_q       <= '0;
         pin_ok_q      <= 1'b0;
         pin_fail_q    <= 1'b0;
         card_retain_q <= 1'b0;
         card_eject_q  <= 1'b0;
         card_prev_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         pin_value_q   <= pin_value_d;
         digit_count_q <= digit_count_d;
         tries_q       <= tries_d;
         pin_ok_q      <= pin_ok_d;
         pin_fail_q    <= pin_fail_d;
         card_retain_q <= card_retain_d;
         card_eject_q  <= card_eject_d;
         card_prev_q   <= bus.card_present;
      end
   end

   assign bus.pin_value   = pin_value_q;
   assign bus.digit_count = digit_count_q;
   assign bus.tries       = tries_q;
   assign bus.pin_ok      = pin_ok_q;
   assign bus.pin_fail    = pin_fail_q;
   assign bus.card_retain = card_retain_q;
   assign bus.card_eject  = card_eject_q;
endmodule

// File: tb/tb_atm_pin_entry.sv
// Randomized scoreboard bench for atm_pin_entry against a session-level reference model.
module tb_atm_pin_entry;
   localparam int MAX_TRIES = 3;
`ifdef PIN_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 30000000;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   atm_pin_entry_if bus ();

   atm_pin_entry #(.MAX_TRIES(MAX_TRIES), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit ok;
      bit fail;
      bit eject;
      bit tmo;
      bit retain;
      int value;
      int tries;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;

   // Reference model: a session holding a list of entered digits
   int  digs[$];
   bit  m_session, m_check, m_granted, m_locked, m_prev;
   int  m_fails, m_idle;
   int  stored;

   bit  prev_ok  = 1'b0;
   bit  prev_ret = 1'b0;
   bit  a_ok, a_ret;
   ev_t e_mon;

   function automatic int fold();
      int v = 0;
      foreach (digs[i]) v = v * 10 + digs[i];
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      digs.delete();
      m_session = 0; m_check = 0; m_granted = 0; m_locked = 0;
      m_prev = 1; m_fails = 0; m_idle = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit card, input bit kv, input int kc);
      ev_t e;
      e = '{default: 0};
      if (m_locked) begin
      end else if (m_check) begin
         m_check = 0;
         if (!card) m_session = 0;
         else if (fold() == stored) begin
            m_session = 0; m_granted = 1; e.ok = 1;
         end else begin
            m_fails++; digs.delete(); e.fail = 1; m_idle = 0;
            if (m_fails >= MAX_TRIES) begin
               m_locked = 1; m_session = 0; e.retain = 1;
            end
         end
      end else if (m_granted) begin
         if (!card) m_granted = 0;
      end else if (m_session) begin
         if (!card) m_session = 0;
         else if (kv) begin
            m_idle = 0;
            if (kc <= 9) begin
               if (digs.size() < 4) digs.push_back(kc);
            end else if (kc == 10) digs.delete();
            else if (kc == 11) begin
               if (digs.size() == 4) m_check = 1;
            end else if (kc == 12) begin
               m_session = 0; e.eject = 1;
            end
         end
`ifdef PIN_TIMEOUT_EN
         else if (m_idle == TMO - 1) begin
            m_session = 0; e.eject = 1; e.tmo = 1;
         end else m_idle++;
`endif
      end else if (card && !m_prev) begin
         m_session = 1; m_fails = 0; m_idle = 0; digs.delete();
      end
      m_prev  = card;
      e.value = fold();
      e.tries = m_fails;
      e.cyc   = cyc;
      if (e.ok || e.fail || e.eject || e.tmo || e.retain) exp_q.push_back(e);
   endtask

   task automatic tick(input bit card, input bit kv, input int kc);
      bus.card_present = card;
      bus.key_valid    = kv;
      bus.key_code     = 4'(kc);
      @(posedge clk);
      #1;
      cyc++;
      model_step(card, kv, kc);
   endtask

   task automatic key(input int k);
      tick(1'b1, 1'b1, k);
      repeat ($urandom_range(0, 2)) tick(1'b1, 1'b0, 0);
   endtask

   task automatic enter_digits(input int p);
      key(p / 1000); key((p / 100) % 10); key((p / 10) % 10); key(p % 10);
   endtask

   task automatic insert_card(input int pin);
      stored = pin;
      bus.stored_pin = 14'(pin);
      tick(1'b0, 1'b0, 0);
      tick(1'b0, 1'b0, 0);
      tick(1'b1, 1'b0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_pin_value",   bus.pin_value,   0);
      check("rst_digit_count", bus.digit_count, 0);
      check("rst_tries",       bus.tries,       0);
      check("rst_pin_ok",      bus.pin_ok,      0);
      check("rst_pin_fail",    bus.pin_fail,    0);
      check("rst_card_retain", bus.card_retain, 0);
      check("rst_card_eject",  bus.card_eject,  0);
      check("rst_timeout",     bus.timeout,     0);
      #2;
      reset = 1'b1;
   endtask

   // Monitor: level checks every cycle, pulse/edge events popped from the scoreboard
   initial begin : monitor
      forever begin
         @(negedge clk);
         check("pin_value",   bus.pin_value,   fold());
         check("digit_count", bus.digit_count, digs.size());
         check("tries",       bus.tries,       m_fails);
         check("pin_ok",      bus.pin_ok,      m_granted);
         check("card_retain", bus.card_retain, m_locked);
         a_ok  = bus.pin_ok && !prev_ok;
         a_ret = bus.card_retain && !prev_ret;
         if (a_ok || bus.pin_fail || bus.card_eject || bus.timeout || a_ret) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL event_unexpected: ok=%0b fail=%0b eject=%0b tmo=%0b retain=%0b expected none (t=%0t)",
                        a_ok, bus.pin_fail, bus.card_eject, bus.timeout, a_ret, $time);
            end else begin
               e_mon = exp_q.pop_front();
               check("ev_cycle",  cyc,            e_mon.cyc);
               check("ev_ok",     a_ok,           e_mon.ok);
               check("ev_fail",   bus.pin_fail,   e_mon.fail);
               check("ev_eject",  bus.card_eject, e_mon.eject);
               check("ev_tmo",    bus.timeout,    e_mon.tmo);
               check("ev_retain", a_ret,          e_mon.retain);
               check("ev_value",  bus.pin_value,  e_mon.value);
               check("ev_tries",  bus.tries,      e_mon.tries);
            end
         end
         prev_ok  = bus.pin_ok;
         prev_ret = bus.card_retain;
      end
   end

   initial begin : stimulus
      int r, n;
      reset            = 1'b0;
      bus.card_present = 1'b0;
      bus.key_valid    = 1'b0;
      bus.key_code     = 4'h0;
      bus.stored_pin   = 14'd8030;
      stored           = 8030;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Correct PIN, enter-to-grant latency
      insert_card(8030);
      enter_digits(8030);
      check("d_value_8030", bus.pin_value, 8030);
      tick(1'b1, 1'b1, 11);
      check("d_ok_after_1clk", bus.pin_ok, 0);
      tick(1'b1, 1'b0, 0);
      check("d_ok_after_2clk", bus.pin_ok, 1);
      repeat (3) tick(1'b1, 1'b1, 5);
      check("d_granted_frozen", bus.pin_value, 8030);

      // Clear then a fifth digit that must be ignored
      insert_card(8030);
      key(9); key(9); key(10);
      enter_digits(8030); key(1);
      check("d_fifth_ignored", bus.pin_value, 8030);
      check("d_count_max", bus.digit_count, 4);
      key(4); key(11); tick(1'b1, 1'b0, 0);
      check("d_ok_after_clear", bus.pin_ok, 1);

      // Card pulled on the Enter cycle
      insert_card(8030);
      enter_digits(8030);
      tick(1'b0, 1'b1, 11);
      repeat (3) tick(1'b0, 1'b0, 0);
      check("d_pull_no_ok", bus.pin_ok, 0);

      // Three wrong entries lock the card; a correct entry afterwards is ignored
      insert_card(8030);
      repeat (3) begin enter_digits(1234); key(11); tick(1'b1, 1'b0, 0); end
      check("d_lock_tries", bus.tries, 3);
      check("d_lock_retain", bus.card_retain, 1);
      enter_digits(8030); key(11); tick(1'b0, 1'b0, 0); tick(1'b1, 1'b0, 0);
      check("d_lock_no_ok", bus.pin_ok, 0);
      check("d_lock_hold", bus.card_retain, 1);
      do_reset();

      // Reset in the middle of entry, card left in
      insert_card(8030);
      key(1); key(2); key(3);
      check("d_mid_count", bus.digit_count, 3);
      do_reset();
      key(4); key(11); repeat (3) tick(1'b1, 1'b0, 0);
      check("d_post_rst_ok", bus.pin_ok, 0);

`ifdef PIN_TIMEOUT_EN
      insert_card(8030);
      tick(1'b1, 1'b1, 5);
      repeat (TMO - 1) tick(1'b1, 1'b0, 0);
      check("d_tmo_early", bus.timeout, 0);
      tick(1'b1, 1'b0, 0);
      check("d_tmo_pulse", bus.timeout, 1);
      check("d_tmo_eject", bus.card_eject, 1);
      insert_card(8030);
      tick(1'b1, 1'b1, 5);
      repeat (TMO - 1) tick(1'b1, 1'b0, 0);
      tick(1'b1, 1'b1, 6);
      check("d_tmo_key_wins", bus.timeout, 0);
      repeat (TMO) tick(1'b1, 1'b0, 0);
      check("d_tmo_restart", bus.timeout, 1);
`endif

      // Randomized sessions
      for (int s = 0; s < 60; s++) begin
         insert_card(($urandom_range(0, 3) == 0) ? 8030 : int'($urandom_range(0, 9999)));
         n = $urandom_range(4, 14);
         for (int a = 0; a < n; a++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
               enter_digits(($urandom_range(0, 1) == 0) ? stored : int'($urandom_range(0, 9999)));
               key(11);
            end else if (r < 70) key($urandom_range(0, 15));
            else if (r < 85) repeat ($urandom_range(1, 4)) tick(1'b1, 1'b0, 0);
            else if (r < 95) begin
               tick(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
               tick(1'b1, 1'b0, 0);
            end else do_reset();
            if (m_locked) begin
               repeat (2) tick(1'b1, 1'b1, $urandom_range(0, 15));
               do_reset();
            end
         end
      end

      repeat (3) tick(1'b0, 1'b0, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/atm_pin_entry.md
ATM_PIN_ENTRY -- requirements
Module: atm_pin_entry

Interface
REQ-001 Parameter MAX_TRIES, default 3, failed PIN attempts before card retention.
REQ-002 Parameter TIMEOUT_CYCLES, default 30000000, idle clocks allowed between keypresses.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 card_present  input  1  level; 1 while a card is in the reader.
REQ-006 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-007 key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC cancel, 0xD-0xF ignored.
REQ-008 stored_pin  input  14  binary PIN of the inserted card, stable while card_present=1.
REQ-009 pin_value  output  14  binary value of the digits entered so far.
REQ-010 digit_count  output  3  digits entered, 0-4.
REQ-011 pin_ok  output  1  level; high in GRANTED.
REQ-012 pin_fail  output  1  one-cycle pulse per wrong PIN.
REQ-013 tries  output  2  failed attempts this session.
REQ-014 card_retain  output  1  level; high in LOCKED.
REQ-015 card_eject  output  1  one-cycle pulse on cancel or timeout.
REQ-016 timeout  output  1  one-cycle pulse on inactivity expiry.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, COLLECT, CHECK, GRANTED, LOCKED.
REQ-018 IDLE->COLLECT on a card_present 0->1 edge; tries, pin_value and digit_count clear on that edge.
REQ-019 In COLLECT, a digit with digit_count<4 SHALL update pin_value to pin_value*10+digit and increment digit_count; with digit_count=4 it is ignored.
REQ-020 The arithmetic SHALL be 14-bit; 9999 is the maximum and never overflows.
REQ-021 Clear SHALL zero pin_value and digit_count without changing tries.
REQ-022 Enter with digit_count<4 SHALL be ignored; with digit_count=4 the FSM goes to CHECK on the next edge.
REQ-023 CHECK SHALL last one cycle. On a match it goes to GRANTED. On a mismatch it pulses pin_fail, increments tries and clears the digits; it then goes to LOCKED if tries reaches MAX_TRIES, otherwise to COLLECT.
REQ-024 Enter-to-pin_ok latency SHALL be 2 clocks.
REQ-025 GRANTED SHALL hold pin_ok=1 and pin_value frozen until card_present=0, then go to IDLE.
REQ-026 Cancel in COLLECT SHALL pulse card_eject and go to IDLE.
REQ-027 LOCKED SHALL hold card_retain=1, ignore all keys and card_present, and exit only by reset.
REQ-028 In every state except LOCKED, card_present=0 SHALL force IDLE on the next edge; this has priority over a simultaneous key.
REQ-029 Keys received in IDLE, CHECK or GRANTED SHALL be ignored.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE and clear pin_value, digit_count, tries and the timer.
REQ-032 reset=0 SHALL also clear pin_ok, pin_fail, card_retain, card_eject and timeout.
REQ-033 Reset asserted mid-session SHALL discard the session; after release a new card_present edge is required.

Configuration
REQ-034 When PIN_TIMEOUT_EN is defined, the COLLECT timer SHALL restart on every key_valid.
REQ-035 When PIN_TIMEOUT_EN is defined and TIMEOUT_CYCLES clocks pass with no key, the block SHALL pulse timeout and card_eject and go to IDLE.
REQ-036 When PIN_TIMEOUT_EN is defined, a key arriving on the expiry cycle SHALL win and restart the timer.
REQ-037 When PIN_TIMEOUT_EN is undefined, no timer SHALL exist, COLLECT SHALL wait indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-038 stored_pin=8030, insert card, keys 8,0,3,0,Enter -> pin_value=8030 after the fourth digit, pin_ok=1 two clocks after Enter.
REQ-039 Three entries of 1,2,3,4,Enter -> pin_fail pulses three times, tries=3, card_retain=1; a later 8030 entry is ignored.
REQ-040 Keys 9,9,Clear,8,0,3,0,1,Enter -> the fifth digit is ignored, pin_value=8030, pin_ok=1.
REQ-041 card_present dropped on the same cycle as Enter -> IDLE, no pin_ok, no pin_fail.
REQ-042 With PIN_TIMEOUT_EN and TIMEOUT_CYCLES=16, one digit then 16 idle clocks -> timeout and card_eject pulse together, state IDLE.
REQ-043 Reset pulsed low mid-COLLECT with digit_count=3 -> all outputs 0 immediately, no pin_ok after release.
